// File: rtl/iecdrv_pkg.sv
// Shared drive types: half-track index and the flush-queue entry.
// Pure declarations; no latency or backpressure.
package iecdrv_pkg;

    typedef logic [6:0] htrack_t;

    typedef struct packed {
        htrack_t htrack;
        logic    side;
    } save_entry_t;

    localparam int MAX_HTRACK_1541   = 84;
    localparam int RESET_HTRACK_1541 = 36;

endpackage

// File: rtl/iecdrv_head_tracker_if.sv
// Track-flush request channel: head entry presented while save_req is high.
// Valid/ready: the entry is consumed on a clk where save_req and save_ack are both high.
interface iecdrv_head_tracker_if;
    import iecdrv_pkg::*;

    logic    save_req;
    htrack_t save_htrack;
    logic    save_side;
    logic    save_ack;

    modport master (
        output save_req,
        output save_htrack,
        output save_side,
        input  save_ack
    );

    modport slave (
        input  save_req,
        input  save_htrack,
        input  save_side,
        output save_ack
    );

endinterface

// File: rtl/iecdrv_save_fifo.sv
// Flush-request FIFO, QDEPTH entries, head visible combinationally; 1 clk push-to-visible.
// A push while full is accepted only if a pop happens the same clk; otherwise it is ignored.
module iecdrv_save_fifo
    import iecdrv_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        push,
    input  save_entry_t push_dat,
    input  logic        pop,
    output logic        full,
    output logic        empty,
    output save_entry_t head
);

    localparam int AW = $clog2(QDEPTH);

    save_entry_t   mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(QDEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    a_count_range: assert property (@(posedge clk) disable iff (reset)
        count <= (AW+1)'(QDEPTH));

endmodule

// File: rtl/iecdrv_head_tracker.sv
// Drive head tracker: stepper phases to half-track, dirty-track flush queue, disk-change timer.
// htrack moves 2 clk after a new stp; flush queue is valid/ready and drops with sticky save_ovf when full.
module iecdrv_head_tracker
    import iecdrv_pkg::*;
#(
    parameter int MAX_HTRACK   = MAX_HTRACK_1541,
    parameter int RESET_HTRACK = RESET_HTRACK_1541,
    parameter int SIDES        = 1,
    parameter int QDEPTH       = 2,
    parameter int TMO_W        = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [1:0]  stp,
    input  logic        mtr,
    input  logic        act,
    input  logic        we,
    input  logic        side,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [31:0] img_size,
    output htrack_t     htrack,
    output logic        side_o,
    output logic        tr00_sense_n,
    output logic        wps_n,
    output logic        disk_present,
    output logic        disk_ready,
    output logic        save_ovf,
    iecdrv_head_tracker_if.master save
);

    logic [1:0]       stp_old;
    logic [1:0]       move;
    logic             step_up;
    logic             step_dn;
    logic             step_any;
    logic             side_nxt;
    logic             side_chg;
    logic             dirty;
    logic             flush;
    logic             push;
    logic             pop;
    logic             q_full;
    logic             q_empty;
    logic             mnt_d;
    logic             mount_edge;
    logic             readonly;
    logic             present;
    logic [TMO_W-1:0] tmo;
    save_entry_t      push_dat;
    save_entry_t      head;

    // Phase difference modulo 4: 1 is one phase forward, 3 one phase back.
    assign move       = stp - stp_old;
    assign step_any   = step_up | step_dn;
    assign side_nxt   = (SIDES == 2) ? side : 1'b0;
    assign side_chg   = (side_nxt != side_o);
    assign mount_edge = img_mounted & ~mnt_d;
    assign flush      = dirty & (step_any | side_chg | ~act);
    assign push       = flush & ~mount_edge;
    assign pop        = save.save_req & save.save_ack;
    assign push_dat   = '{htrack: htrack, side: side_o};

    always_ff @(posedge clk) begin
        stp_old <= stp;
        if (reset) begin
            step_up <= 1'b0;
            step_dn <= 1'b0;
        end else begin
            step_up <= mtr & (move == 2'd1);
            step_dn <= mtr & (move == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            htrack <= htrack_t'(RESET_HTRACK);
            side_o <= 1'b0;
        end else begin
            side_o <= side_nxt;
            if (step_up) begin
                if (htrack < htrack_t'(MAX_HTRACK)) begin
                    htrack <= htrack + 7'd1;
                end
            end else if (step_dn) begin
                if (htrack != '0) begin
                    htrack <= htrack - 7'd1;
                end
            end
        end
    end

    // A write in the flush clk marks the new position dirty, not the old one.
    always_ff @(posedge clk) begin
        if (reset || mount_edge) begin
            dirty <= 1'b0;
        end else if (we) begin
            dirty <= 1'b1;
        end else if (flush) begin
            dirty <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            save_ovf <= 1'b0;
        end else if (push && q_full && !pop) begin
            save_ovf <= 1'b1;
        end
    end

    iecdrv_save_fifo #(
        .QDEPTH (QDEPTH)
    ) u_save_fifo (
        .clk      (clk),
        .reset    (reset),
        .clr      (mount_edge),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .full     (q_full),
        .empty    (q_empty),
        .head     (head)
    );

    assign save.save_req    = ~q_empty;
    assign save.save_htrack = head.htrack;
    assign save.save_side   = head.side;

    // Mount restarts the change timer; presence is only reported once it expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            mnt_d        <= 1'b0;
            tmo          <= '0;
            readonly     <= 1'b0;
            present      <= 1'b0;
            disk_present <= 1'b0;
            disk_ready   <= 1'b0;
        end else begin
            mnt_d      <= img_mounted;
            disk_ready <= (tmo == '0);
            if (mount_edge) begin
                tmo          <= '1;
                readonly     <= img_readonly;
                present      <= |img_size;
                disk_present <= 1'b0;
            end else begin
                if (ce && tmo != '0) begin
                    tmo <= tmo - 1'b1;
                end
                if (tmo == '0) begin
                    disk_present <= present;
                end
            end
        end
    end

    assign tr00_sense_n = |htrack;
    assign wps_n        = ~readonly ^ tmo[TMO_W-2];

    a_htrack_range: assert property (@(posedge clk) disable iff (reset)
        htrack <= htrack_t'(MAX_HTRACK));

    a_single_side: assert property (@(posedge clk) disable iff (reset)
        (SIDES == 2) || !side_o);

endmodule

// File: tb/tb_iecdrv_head_tracker.sv
// Directed bench for iecdrv_head_tracker with a per-cycle reference model and literal spot checks.
module tb_iecdrv_head_tracker;

    localparam int MAXH   = 84;
    localparam int RSTH   = 36;
    localparam int SIDES  = 2;
    localparam int QDEPTH = 2;
    localparam int TMO_W  = 6;
    localparam int TMAX   = (1 << TMO_W) - 1;

    logic        clk;
    logic        reset;
    logic        ce;
    logic [1:0]  stp;
    logic        mtr;
    logic        act;
    logic        we;
    logic        side;
    logic        img_mounted;
    logic        img_readonly;
    logic [31:0] img_size;
    logic [6:0]  htrack;
    logic        side_o;
    logic        tr00_sense_n;
    logic        wps_n;
    logic        disk_present;
    logic        disk_ready;
    logic        save_ovf;

    iecdrv_head_tracker_if sif ();

    iecdrv_head_tracker #(
        .MAX_HTRACK   (MAXH),
        .RESET_HTRACK (RSTH),
        .SIDES        (SIDES),
        .QDEPTH       (QDEPTH),
        .TMO_W        (TMO_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .stp          (stp),
        .mtr          (mtr),
        .act          (act),
        .we           (we),
        .side         (side),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size),
        .htrack       (htrack),
        .side_o       (side_o),
        .tr00_sense_n (tr00_sense_n),
        .wps_n        (wps_n),
        .disk_present (disk_present),
        .disk_ready   (disk_ready),
        .save_ovf     (save_ovf),
        .save         (sif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: drive state as plain integers and a queue of pending flushes.
    bit m_valid = 0;
    int m_ht, m_side, m_dirty, m_pend, m_stp_old, m_mnt;
    int m_tmo, m_ro, m_pres, m_dpres, m_rdy, m_ovf;
    int q_ht[$];
    int q_sd[$];

    always @(posedge clk) begin : model
        int  nht;
        int  nside;
        int  mv;
        bit  mount;
        bit  flush;
        if (reset) begin
            m_valid   = 1;
            m_ht      = RSTH;
            m_side    = 0;
            m_dirty   = 0;
            m_pend    = 0;
            m_stp_old = int'(stp);
            m_mnt     = 0;
            m_tmo     = 0;
            m_ro      = 0;
            m_pres    = 0;
            m_dpres   = 0;
            m_rdy     = 0;
            m_ovf     = 0;
            q_ht.delete();
            q_sd.delete();
        end else begin
            mount = img_mounted && (m_mnt == 0);
            nside = (SIDES == 2) ? int'(side) : 0;
            flush = (m_dirty != 0) && (m_pend != 0 || nside != m_side || !act);
            nht   = m_ht + m_pend;
            if (nht > MAXH) nht = MAXH;
            if (nht < 0) nht = 0;
            if (mount) begin
                q_ht.delete();
                q_sd.delete();
            end else begin
                if (q_ht.size() > 0 && sif.save_ack) begin
                    void'(q_ht.pop_front());
                    void'(q_sd.pop_front());
                end
                if (flush) begin
                    if (q_ht.size() < QDEPTH) begin
                        q_ht.push_back(m_ht);
                        q_sd.push_back(m_side);
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            if (mount) m_dirty = 0;
            else if (we) m_dirty = 1;
            else if (flush) m_dirty = 0;
            m_ht   = nht;
            m_side = nside;
            mv     = (int'(stp) - m_stp_old) & 3;
            m_pend = !mtr ? 0 : (mv == 1) ? 1 : (mv == 3) ? -1 : 0;
            m_stp_old = int'(stp);
            m_rdy = (m_tmo == 0);
            if (mount) m_dpres = 0;
            else if (m_tmo == 0) m_dpres = m_pres;
            if (mount) begin
                m_tmo  = TMAX;
                m_ro   = int'(img_readonly);
                m_pres = (img_size != 0);
            end else if (ce && m_tmo > 0) begin
                m_tmo = m_tmo - 1;
            end
            m_mnt = int'(img_mounted);
        end
    end

    always @(negedge clk) begin : compare
        if (m_valid) begin
            chk("htrack", int'(htrack), m_ht);
            chk("side_o", int'(side_o), m_side);
            chk("tr00_sense_n", int'(tr00_sense_n), (m_ht != 0));
            chk("wps_n", int'(wps_n), (m_ro == 0) ^ ((m_tmo >> (TMO_W - 2)) & 1));
            chk("disk_ready", int'(disk_ready), m_rdy);
            chk("disk_present", int'(disk_present), m_dpres);
            chk("save_ovf", int'(save_ovf), m_ovf);
            chk("save_req", int'(sif.save_req), (q_ht.size() > 0));
            if (q_ht.size() > 0) begin
                chk("save_htrack", int'(sif.save_htrack), q_ht[0]);
                chk("save_side", int'(sif.save_side), q_sd[0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step(input int d);
        stp = stp + 2'(d);
        tick(2);
    endtask

    task automatic dirty_step(input int d);
        we = 1'b1;
        tick(1);
        we = 1'b0;
        step(d);
    endtask

    initial begin : stim
        bit saw0;
        bit saw1;
        reset        = 1'b1;
        ce           = 1'b0;
        stp          = 2'd0;
        mtr          = 1'b1;
        act          = 1'b1;
        we           = 1'b0;
        side         = 1'b0;
        img_mounted  = 1'b0;
        img_readonly = 1'b0;
        img_size     = 32'd0;
        sif.save_ack = 1'b0;

        tick(2);
        chk("lit_reset_htrack", int'(htrack), 36);
        chk("lit_reset_save_req", int'(sif.save_req), 0);
        chk("lit_reset_ready", int'(disk_ready), 0);
        chk("lit_reset_wps_n", int'(wps_n), 1);
        reset = 1'b0;
        tick(1);
        chk("lit_ready_after_reset", int'(disk_ready), 1);

        // Phase walk 0,1,2,3,0 at 4-clk spacing: one half-track per phase, 2 clk latency.
        for (int i = 1; i <= 4; i++) begin
            stp = 2'(i);
            tick(1);
            chk("lit_step_latency", int'(htrack), 35 + i);
            tick(1);
            chk("lit_step_value", int'(htrack), 36 + i);
            tick(2);
        end
        stp = 2'd2;
        tick(4);
        chk("lit_move2_nochange", int'(htrack), 40);

        // Single dirty flush and ack.
        dirty_step(1);
        chk("lit_flush_req", int'(sif.save_req), 1);
        chk("lit_flush_htrack", int'(sif.save_htrack), 40);
        chk("lit_flush_newpos", int'(htrack), 41);
        sif.save_ack = 1'b1;
        tick(1);
        sif.save_ack = 1'b0;
        chk("lit_flush_popped", int'(sif.save_req), 0);

        // Full queue with simultaneous pop and push.
        dirty_step(1);
        dirty_step(1);
        we = 1'b1;
        tick(1);
        we = 1'b0;
        stp = stp + 2'd1;
        tick(1);
        sif.save_ack = 1'b1;
        tick(1);
        chk("lit_fullpush_ovf", int'(save_ovf), 0);
        chk("lit_fullpush_head", int'(sif.save_htrack), 42);
        tick(1);
        chk("lit_fullpush_next", int'(sif.save_htrack), 43);
        tick(1);
        sif.save_ack = 1'b0;
        chk("lit_fullpush_drained", int'(sif.save_req), 0);

        // Overflow: three flushes into a depth-2 queue with no ack.
        for (int i = 0; i < 4; i++) step(-1);
        chk("lit_back_to_40", int'(htrack), 40);
        for (int i = 0; i < 3; i++) dirty_step(1);
        chk("lit_ovf_set", int'(save_ovf), 1);
        chk("lit_ovf_head", int'(sif.save_htrack), 40);
        sif.save_ack = 1'b1;
        tick(1);
        chk("lit_ovf_second", int'(sif.save_htrack), 41);
        tick(1);
        sif.save_ack = 1'b0;
        chk("lit_ovf_drained", int'(sif.save_req), 0);
        chk("lit_ovf_sticky", int'(save_ovf), 1);

        // Reset with a queued entry.
        dirty_step(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("lit_reset_flushq", int'(sif.save_req), 0);
        chk("lit_reset_ovf", int'(save_ovf), 0);

        // Saturation at both ends.
        for (int i = 0; i < 48; i++) step(1);
        chk("lit_reach_max", int'(htrack), 84);
        step(1);
        chk("lit_sat_max", int'(htrack), 84);
        for (int i = 0; i < 83; i++) step(-1);
        chk("lit_at_1", int'(htrack), 1);
        chk("lit_tr00_high", int'(tr00_sense_n), 1);
        step(-1);
        chk("lit_at_0", int'(htrack), 0);
        chk("lit_tr00_low", int'(tr00_sense_n), 0);
        step(-1);
        chk("lit_sat_0", int'(htrack), 0);

        mtr = 1'b0;
        step(1);
        chk("lit_motor_off", int'(htrack), 0);
        mtr = 1'b1;

        // Side change and activity drop as flush triggers.
        we = 1'b1;
        tick(1);
        we = 1'b0;
        side = 1'b1;
        tick(1);
        chk("lit_side_o", int'(side_o), 1);
        chk("lit_side_flush_req", int'(sif.save_req), 1);
        chk("lit_side_flush_side", int'(sif.save_side), 0);
        sif.save_ack = 1'b1;
        tick(1);
        sif.save_ack = 1'b0;
        step(1);
        we = 1'b1;
        tick(1);
        we = 1'b0;
        act = 1'b0;
        tick(1);
        act = 1'b1;
        chk("lit_act_flush_htrack", int'(sif.save_htrack), 1);
        chk("lit_act_flush_side", int'(sif.save_side), 1);
        sif.save_ack = 1'b1;
        tick(1);
        sif.save_ack = 1'b0;

        // Mount in the same clk as a dirty step: step applies, queue and dirty cleared.
        dirty_step(1);
        we = 1'b1;
        tick(1);
        we = 1'b0;
        stp = stp + 2'd1;
        tick(1);
        img_mounted  = 1'b1;
        img_readonly = 1'b1;
        img_size     = 32'h0002_AB00;
        ce           = 1'b1;
        tick(1);
        chk("lit_mount_step", int'(htrack), 3);
        chk("lit_mount_noflush", int'(sif.save_req), 0);
        chk("lit_mount_wps", int'(wps_n), 1);
        tick(1);
        chk("lit_mount_notready", int'(disk_ready), 0);
        chk("lit_mount_notpresent", int'(disk_present), 0);
        act = 1'b0;
        tick(2);
        act = 1'b1;
        chk("lit_mount_dirty_clr", int'(sif.save_req), 0);
        saw0 = 0;
        saw1 = 0;
        for (int i = 0; i < 90; i++) begin
            ce = (i % 4 != 3);
            tick(1);
            if (wps_n) saw1 = 1;
            else saw0 = 1;
        end
        ce = 1'b0;
        chk("lit_wps_toggled", int'(saw0 && saw1), 1);
        chk("lit_final_ready", int'(disk_ready), 1);
        chk("lit_final_present", int'(disk_present), 1);
        chk("lit_final_wps", int'(wps_n), 0);
        chk("lit_final_q_empty", int'(sif.save_req), 0);
        img_mounted = 1'b0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
